// File: rtl/num2strb_burst.sv
// num2strb_burst: turns a (byte offset, byte length) command into a stream of
// registered byte-strobe beats over valid/ready, one beat per handshake.
// Optional build macro: NUM2STRB_BURST_MSB_FIRST_EN (bit-reversed lane order).
module num2strb_burst #(
    parameter int unsigned C_STRB_BIT_NUM = 32,
    parameter int unsigned C_LEN_WIDTH    = 16,
    parameter int unsigned C_OFS_WIDTH    = $clog2(C_STRB_BIT_NUM)
) (
    input  logic                      CLK_I,
    input  logic                      RST_I,
    input  logic                      CMD_VALID_I,
    output logic                      CMD_READY_O,
    input  logic [C_OFS_WIDTH-1:0]    CMD_OFS_I,
    input  logic [C_LEN_WIDTH-1:0]    CMD_LEN_I,
    output logic                      STRB_VALID_O,
    input  logic                      STRB_READY_I,
    output logic [C_STRB_BIT_NUM-1:0] STRB_O,
    output logic                      LAST_O,
    output logic                      DONE_O
);

    // Arithmetic width: wide enough for length, lane count and offset+count
    localparam int unsigned CW = C_LEN_WIDTH + C_OFS_WIDTH + 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                    state, state_n;
    logic [C_STRB_BIT_NUM-1:0] strb_q, strb_n;
    logic                      last_q, last_n;
    logic                      done_q, done_n;
    logic [C_LEN_WIDTH-1:0]    rem_q, rem_n;
    logic                      load_first;
    logic                      handshake;
    logic                      cmd_accept;
    logic [CW-1:0]             len_w, ofs_w, room, n_first, rem_w, n_next;

    // Lane mask by compare (ofs <= lane < ofs+n), so n == lane count never overflows
    function automatic logic [C_STRB_BIT_NUM-1:0] lane_mask(input logic [CW-1:0] ofs,
                                                             input logic [CW-1:0] n);
        logic [C_STRB_BIT_NUM-1:0] m;
        logic [C_STRB_BIT_NUM-1:0] r;
        m = '0;
        r = '0;
        for (int i = 0; i < int'(C_STRB_BIT_NUM); i++) begin
            m[i] = (CW'(i) >= ofs) && (CW'(i) < (ofs + n));
        end
`ifdef NUM2STRB_BURST_MSB_FIRST_EN
        for (int i = 0; i < int'(C_STRB_BIT_NUM); i++) begin
            r[C_STRB_BIT_NUM-1-i] = m[i];
        end
`else
        r = m;
`endif
        return r;
    endfunction

    // Handshake decode; ready again on the final-beat handshake for zero bubble
    assign handshake    = STRB_VALID_O & STRB_READY_I;
    assign CMD_READY_O  = (state == IDLE) | (handshake & last_q);
    assign cmd_accept   = CMD_VALID_I & CMD_READY_O;
    assign STRB_VALID_O = (state == RUN);
    assign STRB_O       = strb_q;
    assign LAST_O       = last_q;
    assign DONE_O       = done_q;

    // Beat sizing: first beat limited by lanes above offset, later beats by full width
    assign len_w   = CW'(CMD_LEN_I);
    assign ofs_w   = CW'(CMD_OFS_I);
    assign room    = CW'(C_STRB_BIT_NUM) - ofs_w;
    assign n_first = (len_w < room) ? len_w : room;
    assign rem_w   = CW'(rem_q);
    assign n_next  = (rem_w < CW'(C_STRB_BIT_NUM)) ? rem_w : CW'(C_STRB_BIT_NUM);

    // Next-state and next-beat computation
    always_comb begin
        state_n    = state;
        strb_n     = strb_q;
        last_n     = last_q;
        rem_n      = rem_q;
        done_n     = 1'b0;
        load_first = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_accept) begin
                    if (CMD_LEN_I == '0) begin
                        done_n = 1'b1;
                    end else begin
                        load_first = 1'b1;
                    end
                end
            end
            RUN: begin
                if (handshake) begin
                    if (!last_q) begin
                        strb_n = lane_mask('0, n_next);
                        rem_n  = rem_q - C_LEN_WIDTH'(n_next);
                        last_n = (rem_w == n_next);
                    end else begin
                        done_n = 1'b1;
                        if (cmd_accept && (CMD_LEN_I != '0)) begin
                            load_first = 1'b1;
                        end else begin
                            state_n = IDLE;
                            strb_n  = '0;
                            last_n  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (load_first) begin
            state_n = RUN;
            strb_n  = lane_mask(ofs_w, n_first);
            rem_n   = C_LEN_WIDTH'(len_w - n_first);
            last_n  = (len_w == n_first);
        end
    end

    // State and beat registers
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state  <= IDLE;
            strb_q <= '0;
            last_q <= 1'b0;
            done_q <= 1'b0;
            rem_q  <= '0;
        end else begin
            state  <= state_n;
            strb_q <= strb_n;
            last_q <= last_n;
            done_q <= done_n;
            rem_q  <= rem_n;
        end
    end

endmodule
